// File: rtl/ifetch_unit.sv
// Instruction fetch stage feeding decode from the 2-way instruction cache.
// It holds the fetch PC and keeps one word read outstanding at a time. Returned
// instructions and their PCs go into a small FIFO for decode. A redirect flushes
// the queue, and any response already in flight is squashed.
//
// Ports:
//   clk_i, reset_i            clock, asynchronous active-high reset
//   redirect_valid_i/pc_i     one-cycle branch/exception redirect and target
//   ic_addr_o, ic_req_o       cache request address and one-cycle request pulse
//   ic_data_i, ic_ready_i     cache read data and one-cycle response strobe
//   if_valid_o/instr_o/pc_o   queue head presented to decode
//   id_ready_i                decode accepts the head this cycle
//   fetch_count_o             responses pushed into the queue
//   discard_count_o           responses squashed by a redirect
//   bubble_count_o            cycles with decode ready but nothing valid
module ifetch_unit #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned           FQ_DEPTH    = 4,
  parameter int unsigned           FQ_PTR_BITS = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic [ADDR_WIDTH-1:0] ic_addr_o,
  output logic                  ic_req_o,
  input  logic [DATA_WIDTH-1:0] ic_data_i,
  input  logic                  ic_ready_i,
  output logic                  if_valid_o,
  output logic [DATA_WIDTH-1:0] if_instr_o,
  output logic [ADDR_WIDTH-1:0] if_pc_o,
  input  logic                  id_ready_i,
  output logic [31:0]           fetch_count_o,
  output logic [31:0]           discard_count_o,
  output logic [31:0]           bubble_count_o
);

  localparam logic [FQ_PTR_BITS:0] FqFull = (FQ_PTR_BITS+1)'(FQ_DEPTH);

  typedef enum logic [1:0] {StIssue, StWait, StDiscard} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic [FQ_PTR_BITS:0]    count_q, count_d;
  logic [FQ_PTR_BITS-1:0]  rd_ptr_q, wr_ptr_q;
  logic [31:0]             fetch_cnt_q, discard_cnt_q, bubble_cnt_q;

  logic [ADDR_WIDTH-1:0]   pc_mem    [FQ_DEPTH];
  logic [DATA_WIDTH-1:0]   instr_mem [FQ_DEPTH];

  logic [ADDR_WIDTH-1:0]   redirect_target;
  logic                    slot_free;
  logic                    push, pop, discard;

  assign redirect_target = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
  assign slot_free       = (count_q < FqFull);

  // Request is gated with reset so the cache never sees a pulse while reset is held.
  assign ic_req_o   = (state_q == StIssue) && slot_free && !redirect_valid_i && !reset_i;
  assign ic_addr_o  = fetch_pc_q;
  assign if_valid_o = (count_q != '0) && !redirect_valid_i;
  assign if_instr_o = instr_mem[rd_ptr_q];
  assign if_pc_o    = pc_mem[rd_ptr_q];
  assign pop        = if_valid_o && id_ready_i;

  assign fetch_count_o   = fetch_cnt_q;
  assign discard_count_o = discard_cnt_q;
  assign bubble_count_o  = bubble_cnt_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    discard    = 1'b0;
    unique case (state_q)
      StIssue: begin
        // A stray ic_ready here is a protocol violation and is ignored.
        if (redirect_valid_i) begin
          fetch_pc_d = redirect_target;
        end else if (slot_free) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (redirect_valid_i) begin
          fetch_pc_d = redirect_target;
          if (ic_ready_i) begin
            discard = 1'b1;
            state_d = StIssue;
          end else begin
            state_d = StDiscard;
          end
        end else if (ic_ready_i) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
          state_d    = StIssue;
        end
      end
      StDiscard: begin
        if (redirect_valid_i) fetch_pc_d = redirect_target;
        if (ic_ready_i) begin
          discard = 1'b1;
          state_d = StIssue;
        end
      end
      default: state_d = StIssue;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= StIssue;
      fetch_pc_q    <= RESET_PC;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      fetch_cnt_q   <= '0;
      discard_cnt_q <= '0;
      bubble_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      // Push and pop are both suppressed during a redirect, so a flush wins cleanly.
      if (redirect_valid_i) begin
        count_q  <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        count_q <= count_d;
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push)    fetch_cnt_q   <= fetch_cnt_q + 32'd1;
      if (discard) discard_cnt_q <= discard_cnt_q + 32'd1;
      if (id_ready_i && !if_valid_o) bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  // Queue storage needs no reset; count_q guards every read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= fetch_pc_q;
      instr_mem[wr_ptr_q] <= ic_data_i;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: a table of per-cycle vectors for sequential
// hits and queue fill, then hand-written sequences for the full-queue stall,
// redirects, PC wrap and asynchronous reset.
module tb_ifetch_unit;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        redirect_valid_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic [31:0] ic_addr_o;
  logic        ic_req_o;
  logic [31:0] ic_data_i = '0;
  logic        ic_ready_i = 1'b0;
  logic        if_valid_o;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_o;
  logic        id_ready_i = 1'b0;
  logic [31:0] fetch_count_o, discard_count_o, bubble_count_o;

  int total = 0;
  int bad   = 0;

  ifetch_unit dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i   (redirect_pc_i),
    .ic_addr_o       (ic_addr_o),
    .ic_req_o        (ic_req_o),
    .ic_data_i       (ic_data_i),
    .ic_ready_i      (ic_ready_i),
    .if_valid_o      (if_valid_o),
    .if_instr_o      (if_instr_o),
    .if_pc_o         (if_pc_o),
    .id_ready_i      (id_ready_i),
    .fetch_count_o   (fetch_count_o),
    .discard_count_o (discard_count_o),
    .bubble_count_o  (bubble_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic [31:0] dat;
    logic        idr;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] instr;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic rst, input logic rv, input logic [31:0] rpc,
                       input logic rdy, input logic [31:0] dat, input logic idr);
    @(negedge clk_i);
    reset_i          = rst;
    redirect_valid_i = rv;
    redirect_pc_i    = rpc;
    ic_ready_i       = rdy;
    ic_data_i        = dat;
    id_ready_i       = idr;
    #1;
  endtask

  task automatic chk_if(input string name, input logic req, input logic [31:0] addr,
                        input logic vld);
    chk({name, "_req"}, {31'd0, ic_req_o}, {31'd0, req});
    chk({name, "_addr"}, ic_addr_o, addr);
    chk({name, "_vld"}, {31'd0, if_valid_o}, {31'd0, vld});
  endtask

  task automatic chk_head(input string name, input logic [31:0] pc, input logic [31:0] instr);
    chk({name, "_pc"}, if_pc_o, pc);
    chk({name, "_instr"}, if_instr_o, instr);
  endtask

  initial begin
    // Sequential hits, one response the cycle after each request, then fill to full.
    vecs[0]  = '{1'b0, 32'h0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h00, 1'b0, 32'h0,  32'h0};
    vecs[1]  = '{1'b0, 32'h0, 1'b1, 32'hA5A50000, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0,  32'h0};
    vecs[2]  = '{1'b0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h04, 1'b1, 32'h0,  32'hA5A50000};
    vecs[3]  = '{1'b0, 32'h0, 1'b1, 32'hA5A50004, 1'b1, 1'b0, 32'h04, 1'b0, 32'h0,  32'h0};
    vecs[4]  = '{1'b0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h08, 1'b1, 32'h4,  32'hA5A50004};
    vecs[5]  = '{1'b0, 32'h0, 1'b1, 32'hA5A50008, 1'b1, 1'b0, 32'h08, 1'b0, 32'h0,  32'h0};
    vecs[6]  = '{1'b0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0C, 1'b1, 32'h8,  32'hA5A50008};
    vecs[7]  = '{1'b0, 32'h0, 1'b1, 32'hA5A5000C, 1'b1, 1'b0, 32'h0C, 1'b0, 32'h0,  32'h0};
    vecs[8]  = '{1'b0, 32'h0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h10, 1'b1, 32'hC,  32'hA5A5000C};
    vecs[9]  = '{1'b0, 32'h0, 1'b1, 32'hA5A50010, 1'b0, 1'b0, 32'h10, 1'b1, 32'hC,  32'hA5A5000C};
    vecs[10] = '{1'b0, 32'h0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h14, 1'b1, 32'hC,  32'hA5A5000C};
    vecs[11] = '{1'b0, 32'h0, 1'b1, 32'hA5A50014, 1'b0, 1'b0, 32'h14, 1'b1, 32'hC,  32'hA5A5000C};
    vecs[12] = '{1'b0, 32'h0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h18, 1'b1, 32'hC,  32'hA5A5000C};
    vecs[13] = '{1'b0, 32'h0, 1'b1, 32'hA5A50018, 1'b0, 1'b0, 32'h18, 1'b1, 32'hC,  32'hA5A5000C};
    vecs[14] = '{1'b0, 32'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h1C, 1'b1, 32'hC,  32'hA5A5000C};

    // Reset state while reset is held.
    #1 reset_i = 1'b1;
    #1;
    chk_if("rst", 1'b0, 32'h0, 1'b0);
    chk("rst_fetch", fetch_count_o, 32'd0);

    for (int i = 0; i < 15; i++) begin
      drive(1'b0, vecs[i].rv, vecs[i].rpc, vecs[i].rdy, vecs[i].dat, vecs[i].idr);
      chk_if($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].vld);
      if (vecs[i].vld) chk_head($sformatf("vec%0d", i), vecs[i].pc, vecs[i].instr);
      if (i == 8) begin
        chk("seq_fetch", fetch_count_o, 32'd4);
        chk("seq_bubble", bubble_count_o, 32'd4);
      end
    end

    // Queue full: no request while decode stalls.
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      chk_if("full_stall", 1'b0, 32'h1C, 1'b1);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk_if("full_pop", 1'b0, 32'h1C, 1'b1);
    chk_head("full_pop", 32'hC, 32'hA5A5000C);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk_if("after_pop", 1'b1, 32'h1C, 1'b1);
    chk_head("after_pop", 32'h10, 32'hA5A50010);

    // Redirect during a miss: late response is squashed.
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk_if("miss_w1", 1'b0, 32'h1C, 1'b1);
    drive(1'b0, 1'b1, 32'h103, 1'b0, 32'h0, 1'b0);
    chk_if("miss_redir", 1'b0, 32'h1C, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      chk_if("miss_discard", 1'b0, 32'h100, 1'b0);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
    chk_if("miss_late_rdy", 1'b0, 32'h100, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk_if("miss_next", 1'b1, 32'h100, 1'b0);
    chk("miss_discard_cnt", discard_count_o, 32'd1);
    chk("miss_fetch_cnt", fetch_count_o, 32'd7);

    // Redirect coincident with ic_ready and a pop attempt.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hA5A50100, 1'b0);
    chk_if("co_fill", 1'b0, 32'h100, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk_if("co_req", 1'b1, 32'h104, 1'b1);
    chk_head("co_req", 32'h100, 32'hA5A50100);
    drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h1234, 1'b1);
    chk_if("co_redir", 1'b0, 32'h104, 1'b0);

    // PC wrap past the top of the address space.
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk_if("wrap_req0", 1'b1, 32'hFFFF_FFFC, 1'b0);
    chk("co_discard_cnt", discard_count_o, 32'd2);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h5A5AFFFC, 1'b0);
    chk_if("wrap_rdy0", 1'b0, 32'hFFFF_FFFC, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk_if("wrap_req1", 1'b1, 32'h0, 1'b1);
    chk_head("wrap_head0", 32'hFFFF_FFFC, 32'h5A5AFFFC);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hA5A50000, 1'b1);
    chk_if("wrap_rdy1", 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk_if("wrap_req2", 1'b1, 32'h4, 1'b1);
    chk_head("wrap_head1", 32'h0, 32'hA5A50000);
    chk("wrap_fetch_cnt", fetch_count_o, 32'd10);
    chk("wrap_bubble_cnt", bubble_count_o, 32'd6);

    // Async reset between edges while a request is outstanding.
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk_if("pre_rst", 1'b0, 32'h4, 1'b1);
    #2 reset_i = 1'b1;
    #1;
    chk_if("mid_rst", 1'b0, 32'h0, 1'b0);
    chk("mid_rst_fetch", fetch_count_o, 32'd0);
    chk("mid_rst_discard", discard_count_o, 32'd0);
    chk("mid_rst_bubble", bubble_count_o, 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hBAD0BAD0, 1'b0);
    chk_if("post_rst_req", 1'b1, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk_if("stale_ignored", 1'b0, 32'h0, 1'b0);
    chk("stale_fetch", fetch_count_o, 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hA5A50000, 1'b0);
    chk_if("post_rst_rdy", 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk_if("post_rst_next", 1'b1, 32'h4, 1'b1);
    chk_head("post_rst_head", 32'h0, 32'hA5A50000);
    chk("post_rst_fetch", fetch_count_o, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
